din_source: RTL and testbench
=============================

Name: din_source

Overview:
- Transmitting end of the valid-only din interface (din_valid/din_data, no backpressure). Drives that interface for blocks that consume it.
- Accepts words from an upstream ready/valid producer and buffers them in a small FIFO.
- Emits one word per beat, with a programmable minimum idle gap between beats.
- Used in testbenches and in RTL as the canonical din driver, clocked by the same clk/rst_n domain as the sink.

Parameters:
- DWIDTH, 16, data word width (matches din_data of the sink)
- DEPTH, 8, FIFO depth in words; power of two, >=2
- GWIDTH, 8, width of gap_cfg

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  allows new beats to start
- gap_cfg  input  GWIDTH  minimum idle cycles between consecutive beats
- src_valid  input  1  upstream word valid
- src_ready  output  1  FIFO can accept; equals !full (combinational from registered level)
- src_data  input  DWIDTH  upstream word
- din_valid  output  1  beat valid (registered)
- din_data  output  DWIDTH  beat data (registered)
- fifo_level  output  $clog2(DEPTH)+1  words currently buffered
- overflow_err  output  1  sticky; set when src_valid is high while src_ready is low

Behaviour:
- Reset (async, rst_n=0):
  - din_valid=0, din_data=0, fifo_level=0, overflow_err=0.
  - FSM to IDLE; FIFO pointers cleared and contents discarded.
  - A reset mid-burst aborts immediately; no partial beat is emitted after release.
- Push: when src_valid && src_ready at a rising edge.
  - src_ready=0 when level==DEPTH, even if a pop occurs in the same cycle (no push-through when full).
- Pop: occurs only on the FSM entry into SEND. Simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, SEND, GAP.
  - IDLE: din_valid=0. Go to SEND (pop) when enable && !empty.
  - SEND: din_valid=1 for exactly one cycle, din_data=popped word. Then:
    - gap_cfg==0 && enable && !empty: stay in SEND (pop again, back-to-back).
    - gap_cfg>0: go to GAP and load gap_cnt=gap_cfg (sampled in this cycle).
    - otherwise: go to IDLE.
  - GAP: din_valid=0, gap_cnt decrements each cycle. When gap_cnt==1:
    - enable && !empty: go to SEND.
    - otherwise: go to IDLE.
- Gap guarantee: a beat at cycle t is followed by exactly gap_cfg idle cycles before the next beat at t+gap_cfg+1, if data and enable are present. More idle cycles follow otherwise.
- Gap configuration timing: gap_cfg changes take effect at the next beat; an in-progress GAP is not reloaded.
- Latency: a word pushed at edge k into an empty FIFO with FSM in IDLE gives din_valid=1 after edge k+1, so it is seen in cycle k+1.
- enable deassertion: an in-progress GAP runs to completion and the FSM then goes to IDLE. Words stay buffered.
- din_data holds the last beat value while din_valid=0.
- Pointers wrap modulo DEPTH; level saturates by construction (no push when full, no pop when empty).
- overflow_err clears only by reset.

Optional Feature:
- Macro: DIN_SOURCE_CNT_EN.
- When defined: adds output tx_count [31:0]. It resets to 0 and increments by 1 on each cycle with din_valid=1, wrapping 0xFFFF_FFFF to 0.
- When not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package din_pkg:
  - typedef enum logic [1:0] {IDLE, SEND, GAP} din_src_state_t
  - localparam DIN_DWIDTH_DEFAULT=16
  - function for level width, $clog2(DEPTH)+1
- Sub-module din_src_fifo:
  - Synchronous single-clock FIFO with push/pop/full/empty/level and async active-low reset.
  - Parameterised by DWIDTH, DEPTH.
  - Read data is available combinationally at the head, so the FSM can register it into din_data on pop.

Test Plan:
- Reset mid-burst: load 4 words, enable=1, gap_cfg=0; pulse rst_n low during the second beat -> din_valid=0, din_data=0 and fifo_level=0 immediately; no beats after release until new pushes.
- Back-to-back: gap_cfg=0, push 0x0001..0x0008 with enable=1 -> din_valid high for 8 consecutive cycles; din_data 0x0001..0x0008 in order; first beat one cycle after the first push.
- Gap timing: gap_cfg=3, push 0xA5A5, 0x5A5A, 0x1234 -> beats at cycles t, t+4, t+8, with din_valid=0 on exactly 3 cycles between beats.
- Full/overflow: enable=0, push DEPTH=8 words -> fifo_level=8, src_ready=0. One more src_valid cycle sets overflow_err=1 and that word is dropped. Then enable=1 -> exactly 8 beats are emitted.
- Enable gating: gap_cfg=2, 3 words buffered, drop enable during the GAP after beat 1 -> GAP completes, FSM goes to IDLE, and fifo_level holds at 2. Re-enable -> beats resume with din_data intact.
- Counter (DIN_SOURCE_CNT_EN): emit 5 beats -> tx_count=5; without the macro, the bench compiles with tx_count checks excluded.

Source files
------------

// File: rtl/din_pkg.sv
// -----------------------------------------------------------------------------
// din_pkg
// Shared types and helpers for the din_source transmitter.
//   din_src_state_t    : beat scheduler states (IDLE, SEND, GAP)
//   DIN_DWIDTH_DEFAULT : default din_data width
//   din_level_w()      : width of a FIFO occupancy count for a given depth
// -----------------------------------------------------------------------------
package din_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } din_src_state_t;

    localparam int DIN_DWIDTH_DEFAULT = 16;

    // An occupancy count must represent 0..DEPTH inclusive.
    function automatic int din_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/din_source_if.sv
// -----------------------------------------------------------------------------
// din_source_if
// Bundles the upstream ready/valid word stream and the downstream valid-only
// din beat stream handled by din_source.
//   src_valid/src_data/src_ready : upstream producer handshake
//   din_valid/din_data           : transmitted beats (no backpressure)
// Modports:
//   master : the din_source side (accepts src words, drives din beats)
//   slave  : the environment side (produces src words, observes din beats)
// -----------------------------------------------------------------------------
interface din_source_if
    import din_pkg::*;
#(
    parameter int DWIDTH = DIN_DWIDTH_DEFAULT
);

    logic              src_valid;
    logic              src_ready;
    logic [DWIDTH-1:0] src_data;
    logic              din_valid;
    logic [DWIDTH-1:0] din_data;

    modport master (
        input  src_valid,
        input  src_data,
        output src_ready,
        output din_valid,
        output din_data
    );

    modport slave (
        output src_valid,
        output src_data,
        input  src_ready,
        input  din_valid,
        input  din_data
    );

endinterface

// File: rtl/din_src_fifo.sv
// -----------------------------------------------------------------------------
// din_src_fifo
// Single-clock FIFO buffering upstream words for din_source.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push/wdata : write request and word; ignored while full
//   pop        : read request; ignored while empty
//   rdata      : head word, valid combinationally whenever !empty
//   full/empty : occupancy flags decoded from the registered level
//   level      : words currently stored (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module din_src_fifo
    import din_pkg::*;
#(
    parameter  int DWIDTH = DIN_DWIDTH_DEFAULT,
    parameter  int DEPTH  = 8,
    localparam int LW     = din_level_w(DEPTH),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: only words below the level are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/din_source.sv
// -----------------------------------------------------------------------------
// din_source
// Transmitting end of the valid-only din interface. Words from an upstream
// ready/valid producer are buffered in a small FIFO and emitted one per beat,
// with at least gap_cfg idle cycles between consecutive beats.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   enable       : allows new beats to start
//   gap_cfg      : minimum idle cycles between beats, sampled on each beat
//   bus (master) : src_valid/src_data/src_ready in, din_valid/din_data out
//   fifo_level   : words currently buffered
//   overflow_err : sticky, set when src_valid arrives while src_ready is low
//   tx_count     : beats emitted, wrapping 32-bit (only with DIN_SOURCE_CNT_EN)
// Build option:
//   DIN_SOURCE_CNT_EN : adds the tx_count output and its counter.
// -----------------------------------------------------------------------------
module din_source
    import din_pkg::*;
#(
    parameter  int DWIDTH = DIN_DWIDTH_DEFAULT,
    parameter  int DEPTH  = 8,
    parameter  int GWIDTH = 8,
    localparam int LW     = din_level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [GWIDTH-1:0] gap_cfg,
    din_source_if.master      bus,
    output logic [LW-1:0]     fifo_level,
    output logic              overflow_err
`ifdef DIN_SOURCE_CNT_EN
    ,
    output logic [31:0]       tx_count
`endif
);

    din_src_state_t    state;
    din_src_state_t    next_state;
    logic [GWIDTH-1:0] gap_cnt;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DWIDTH-1:0] head;
    logic              beat_valid;
    logic [DWIDTH-1:0] beat_data;
    logic              can_send;

    // Ready comes from the registered level only, so a pop in the same cycle
    // never lets a word push through a full FIFO.
    assign bus.src_ready = ~full;
    assign push          = bus.src_valid & ~full;
    assign can_send      = enable & ~empty;

    din_src_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.src_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (can_send) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (gap_cfg != '0) begin
                    next_state = GAP;
                end else if (can_send) begin
                    next_state = SEND;
                end else begin
                    next_state = IDLE;
                end
            end
            GAP: begin
                // Zero is never loaded, but treat it as the last gap cycle
                // so the FSM cannot stall if it ever appears.
                if (gap_cnt <= GWIDTH'(1)) begin
                    next_state = can_send ? SEND : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Every entry into SEND (including SEND->SEND) consumes one word; every
    // such path already requires a non-empty FIFO.
    assign pop = (next_state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            beat_valid   <= 1'b0;
            beat_data    <= '0;
            overflow_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == SEND && next_state == GAP) begin
                gap_cnt <= gap_cfg;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GWIDTH'(1);
            end
            beat_valid <= pop;
            // din_data holds the last beat while idle.
            if (pop) begin
                beat_data <= head;
            end
            if (bus.src_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign bus.din_valid = beat_valid;
    assign bus.din_data  = beat_data;

`ifdef DIN_SOURCE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count <= '0;
        end else if (beat_valid) begin
            tx_count <= tx_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_din_source.sv
// -----------------------------------------------------------------------------
// tb_din_source
// Self-checking bench for din_source: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic compared against a queue-based
// reference model of the beat scheduling rules.
// -----------------------------------------------------------------------------
module tb_din_source;

    localparam int DWIDTH = 16;
    localparam int DEPTH  = 8;
    localparam int GWIDTH = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [GWIDTH-1:0] gap_cfg;
    logic [LW-1:0]     fifo_level;
    logic              overflow_err;
`ifdef DIN_SOURCE_CNT_EN
    logic [31:0]       tx_count;
`endif

    din_source_if #(.DWIDTH(DWIDTH)) bus ();

    din_source #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .GWIDTH (GWIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .gap_cfg      (gap_cfg),
        .bus          (bus),
        .fifo_level   (fifo_level),
        .overflow_err (overflow_err)
`ifdef DIN_SOURCE_CNT_EN
        ,
        .tx_count     (tx_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words waiting in a queue; a new beat may launch at the end of cycle c
    // when enabled, data is waiting and c >= ready_at, where ready_at is the
    // cycle of the previous beat plus the gap_cfg seen during that beat.
    logic [DWIDTH-1:0] mq [$];
    int                cyc;
    int                ready_at;
    bit                m_valid;
    logic [DWIDTH-1:0] m_data;
    bit                m_ovf;
    logic [31:0]       m_cnt;

    task automatic model_reset();
        mq.delete();
        cyc      = 0;
        ready_at = 0;
        m_valid  = 0;
        m_data   = '0;
        m_ovf    = 0;
        m_cnt    = '0;
    endtask

    task automatic model_edge();
        bit launch;
        bit was_full;
        if (m_valid) ready_at = cyc + int'(gap_cfg);
        launch   = enable && (mq.size() > 0) && (cyc >= ready_at);
        was_full = (mq.size() == DEPTH);
        if (bus.src_valid && was_full) m_ovf = 1;
        if (m_valid) m_cnt = m_cnt + 32'd1;
        if (launch) m_data = mq.pop_front();
        if (bus.src_valid && !was_full) mq.push_back(bus.src_data);
        m_valid = launch;
        cyc++;
    endtask

    task automatic compare_model();
        check("model din_valid", 32'(bus.din_valid), 32'(m_valid));
        check("model din_data", 32'(bus.din_data), 32'(m_data));
        check("model fifo_level", 32'(fifo_level), 32'(mq.size()));
        check("model src_ready", 32'(bus.src_ready), 32'(mq.size() < DEPTH));
        check("model overflow_err", 32'(overflow_err), 32'(m_ovf));
`ifdef DIN_SOURCE_CNT_EN
        check("model tx_count", tx_count, m_cnt);
`endif
    endtask

    // One clock: model follows the edge, DUT is sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    // Call away from the rising edge (e.g. right after a falling edge).
    task automatic do_reset();
        bus.src_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset din_valid", 32'(bus.din_valid), 32'd0);
        check("reset din_data", 32'(bus.din_data), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset overflow_err", 32'(overflow_err), 32'd0);
        check("reset src_ready", 32'(bus.src_ready), 32'd1);
`ifdef DIN_SOURCE_CNT_EN
        check("reset tx_count", tx_count, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic              sv;
        logic [DWIDTH-1:0] sd;
        logic              en;
        logic [GWIDTH-1:0] gap;
        logic              ev;
        logic [DWIDTH-1:0] ed;
        logic [LW-1:0]     el;
    } vec_t;

    vec_t tbl [10];
    int   beats [$];
    int   nbeats;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        enable        = 1'b0;
        gap_cfg       = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        model_reset();
        #12;
        do_reset();

        // ---- back-to-back table: push 1..8 with gap 0, one beat per cycle
        tbl[0] = '{1'b1, 16'h0001, 1'b1, 8'd0, 1'b0, 16'h0000, 4'd1};
        tbl[1] = '{1'b1, 16'h0002, 1'b1, 8'd0, 1'b1, 16'h0001, 4'd1};
        tbl[2] = '{1'b1, 16'h0003, 1'b1, 8'd0, 1'b1, 16'h0002, 4'd1};
        tbl[3] = '{1'b1, 16'h0004, 1'b1, 8'd0, 1'b1, 16'h0003, 4'd1};
        tbl[4] = '{1'b1, 16'h0005, 1'b1, 8'd0, 1'b1, 16'h0004, 4'd1};
        tbl[5] = '{1'b1, 16'h0006, 1'b1, 8'd0, 1'b1, 16'h0005, 4'd1};
        tbl[6] = '{1'b1, 16'h0007, 1'b1, 8'd0, 1'b1, 16'h0006, 4'd1};
        tbl[7] = '{1'b1, 16'h0008, 1'b1, 8'd0, 1'b1, 16'h0007, 4'd1};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 16'h0008, 4'd0};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'h0008, 4'd0};
        for (int i = 0; i < 10; i++) begin
            bus.src_valid = tbl[i].sv;
            bus.src_data  = tbl[i].sd;
            enable        = tbl[i].en;
            gap_cfg       = tbl[i].gap;
            tick();
            check($sformatf("tbl[%0d] din_valid", i), 32'(bus.din_valid), 32'(tbl[i].ev));
            check($sformatf("tbl[%0d] din_data", i), 32'(bus.din_data), 32'(tbl[i].ed));
            check($sformatf("tbl[%0d] fifo_level", i), 32'(fifo_level), 32'(tbl[i].el));
        end
        bus.src_valid = 1'b0;

        // ---- reset mid-burst
        enable  = 1'b0;
        gap_cfg = '0;
        for (int i = 0; i < 4; i++) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 16'h0C00 + 16'(i);
            tick();
        end
        bus.src_valid = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        check("burst second beat", 32'(bus.din_data), 32'h0C01);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-reset no beat", 32'(bus.din_valid), 32'd0);
        end

        // ---- gap timing: gap 3 gives beats 4 cycles apart
        gap_cfg = 8'd3;
        enable  = 1'b1;
        beats.delete();
        for (int i = 0; i < 15; i++) begin
            bus.src_valid = (i < 3);
            bus.src_data  = (i == 0) ? 16'hA5A5 : (i == 1) ? 16'h5A5A : 16'h1234;
            tick();
            if (bus.din_valid) beats.push_back(i);
        end
        bus.src_valid = 1'b0;
        check("gap beat count", 32'(beats.size()), 32'd3);
        if (beats.size() == 3) begin
            check("gap first beat latency", 32'(beats[0]), 32'd1);
            check("gap spacing 1", 32'(beats[1] - beats[0]), 32'd4);
            check("gap spacing 2", 32'(beats[2] - beats[1]), 32'd4);
        end

        // ---- full / overflow
        gap_cfg = '0;
        enable  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 16'h0100 + 16'(i);
            tick();
        end
        bus.src_valid = 1'b0;
        check("full level", 32'(fifo_level), 32'd8);
        check("full src_ready", 32'(bus.src_ready), 32'd0);
        check("full no overflow yet", 32'(overflow_err), 32'd0);
        bus.src_valid = 1'b1;
        bus.src_data  = 16'hDEAD;
        tick();
        bus.src_valid = 1'b0;
        check("overflow set", 32'(overflow_err), 32'd1);
        check("overflow level", 32'(fifo_level), 32'd8);
        enable = 1'b1;
        nbeats = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.din_valid) nbeats++;
        end
        check("drain beat count", 32'(nbeats), 32'd8);
        check("drain last word", 32'(bus.din_data), 32'h0107);
        check("overflow sticky", 32'(overflow_err), 32'd1);

        // ---- enable gating during GAP
        gap_cfg = 8'd2;
        enable  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 16'h0011 * 16'(i + 1);
            tick();
        end
        bus.src_valid = 1'b0;
        enable = 1'b1;
        tick();
        check("gate beat1 valid", 32'(bus.din_valid), 32'd1);
        check("gate beat1 data", 32'(bus.din_data), 32'h0011);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gate idle valid", 32'(bus.din_valid), 32'd0);
            check("gate level held", 32'(fifo_level), 32'd2);
        end
        enable = 1'b1;
        tick();
        check("gate resume valid", 32'(bus.din_valid), 32'd1);
        check("gate resume data", 32'(bus.din_data), 32'h0022);
        for (int i = 0; i < 4; i++) tick();

`ifdef DIN_SOURCE_CNT_EN
        // ---- beat counter
        do_reset();
        gap_cfg = '0;
        enable  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 16'h0700 + 16'(i);
            tick();
        end
        bus.src_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("tx_count after 5 beats", tx_count, 32'd5);
`endif

        // ---- randomized traffic against the model
        do_reset();
        gap_cfg = '0;
        for (int i = 0; i < 2000; i++) begin
            bus.src_valid = ($urandom_range(0, 99) < 60);
            bus.src_data  = 16'($urandom);
            enable        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) gap_cfg = 8'($urandom_range(0, 3));
            tick();
        end
        bus.src_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
